// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-PC generator: state codes, fetch
// exception codes and fetch-group address arithmetic.
package pc_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PEND  = 2'd2;
  localparam state_t ST_FAULT = 2'd3;

  localparam logic [7:0] EXC_ADEL = 8'h40;
  localparam logic [7:0] EXC_NONE = 8'h00;

  function automatic logic [31:0] group_align(input logic [31:0] pc, input logic [31:0] gb);
    return pc & ~(gb - 32'd1);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// Pending-redirect register: holds the redirect that arrived while a fetch
// request was outstanding; an exception always wins over a branch target.
module pc_gen_redirect_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        exc_sel,
  input  logic [31:0] exc_pc,
  input  logic        tgt_sel,
  input  logic [31:0] tgt_pc,
  output logic [31:0] merged_pc,
  output logic        merged_exc
);

  logic        valid_reg, valid_next;
  logic        exc_reg, exc_next;
  logic [31:0] pc_reg, pc_next;
  logic        take_exc, take_tgt;

  // A target may only replace an empty slot or an older target.
  assign take_exc = load && exc_sel;
  assign take_tgt = load && tgt_sel && !exc_sel && !(valid_reg && exc_reg);

  always_comb begin
    merged_pc  = pc_reg;
    merged_exc = exc_reg;
    if (take_exc) begin
      merged_pc  = exc_pc;
      merged_exc = 1'b1;
    end else if (take_tgt) begin
      merged_pc  = tgt_pc;
      merged_exc = 1'b0;
    end
    valid_next = (valid_reg || take_exc || take_tgt) && !clear;
    exc_next   = merged_exc && !clear;
    pc_next    = merged_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      exc_reg   <= 1'b0;
      pc_reg    <= 32'd0;
    end else begin
      valid_reg <= valid_next;
      exc_reg   <= exc_next;
      pc_reg    <= pc_next;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator for the IF stage with redirect handling and misalignment
// detection. Define PC_GEN_PERF_EN to add redirect/stall performance counters.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
  parameter int          FETCH_W   = 1,
  parameter int          NUM_STALL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_STALL-1:0] stall,
  input  logic                 PC_exc_sel,
  input  logic [31:0]          PC_exc_i,
  input  logic                 PC_target_sel,
  input  logic [31:0]          PC_target_i,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [31:0]          PC_o,
  output logic [31:0]          PC_plus4,
  output logic [FETCH_W-1:0]   slot_mask,
  output logic                 flush,
  output logic [7:0]           fetch_exc
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0]          perf_exc_cnt,
  output logic [31:0]          perf_tgt_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam logic [31:0] GB      = 32'(4 * FETCH_W);
  localparam int          GB_LOG2 = $clog2(4 * FETCH_W);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        hold_reg, hold_next;
  logic        flush_reg, flush_next;

  logic        stalled, handshake, redir_any;
  logic [31:0] redir_pc;
  logic        buf_load, buf_clear, buf_merged_exc;
  logic [31:0] buf_merged_pc;

  assign stalled   = |stall;
  assign redir_any = PC_exc_sel || PC_target_sel;
  assign redir_pc  = PC_exc_sel ? PC_exc_i : PC_target_i;

  // hold_reg keeps an unaccepted request alive regardless of stall.
  assign req_valid = hold_reg || ((state_reg == ST_RUN) && !stalled && !is_misaligned(pc_reg[1:0]));
  assign handshake = req_valid && req_ready;

  assign buf_load  = redir_any && (((state_reg == ST_RUN) && req_valid && !req_ready) ||
                                   (state_reg == ST_PEND));
  assign buf_clear = (state_reg == ST_PEND) && handshake;

  pc_gen_redirect_buf u_redirect_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .clear      (buf_clear),
    .exc_sel    (PC_exc_sel),
    .exc_pc     (PC_exc_i),
    .tgt_sel    (PC_target_sel),
    .tgt_pc     (PC_target_i),
    .merged_pc  (buf_merged_pc),
    .merged_exc (buf_merged_exc)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flush_next = 1'b0;
    hold_next  = req_valid && !req_ready;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (req_valid && !req_ready) begin
          if (redir_any) state_next = ST_PEND;
        end else if (redir_any) begin
          pc_next    = redir_pc;
          flush_next = 1'b1;
          state_next = is_misaligned(redir_pc[1:0]) ? ST_FAULT : ST_RUN;
        end else if (handshake) begin
          pc_next = group_align(pc_reg, GB) + GB;
        end
      end
      ST_PEND: begin
        // Includes any redirect arriving in the handshake cycle itself.
        if (handshake) begin
          pc_next    = buf_merged_pc;
          flush_next = 1'b1;
          state_next = is_misaligned(buf_merged_pc[1:0]) ? ST_FAULT : ST_RUN;
        end
      end
      ST_FAULT: begin
        if (redir_any) begin
          pc_next    = redir_pc;
          flush_next = 1'b1;
          state_next = is_misaligned(redir_pc[1:0]) ? ST_FAULT : ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_VEC;
      hold_reg  <= 1'b0;
      flush_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      hold_reg  <= hold_next;
      flush_reg <= flush_next;
    end
  end

  assign PC_o      = pc_reg;
  assign PC_plus4  = pc_reg + 32'd4;
  assign flush     = flush_reg;
  assign fetch_exc = is_misaligned(pc_reg[1:0]) ? EXC_ADEL : EXC_NONE;

  generate
    if (FETCH_W == 1) begin : g_single_slot
      assign slot_mask = 1'b1;
    end else begin : g_multi_slot
      localparam int IDX_W = GB_LOG2 - 2;
      logic [IDX_W-1:0] slot_idx;
      assign slot_idx = pc_reg[GB_LOG2-1:2];
      for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
        assign slot_mask[gi] = (IDX_W'(gi) >= slot_idx);
      end
    end
  endgenerate

`ifdef PC_GEN_PERF_EN
  logic perf_exc_hit, perf_tgt_hit, perf_stall_hit;

  assign perf_exc_hit   = flush_next && ((state_reg == ST_PEND) ? buf_merged_exc : PC_exc_sel);
  assign perf_tgt_hit   = flush_next && !perf_exc_hit;
  assign perf_stall_hit = (state_reg == ST_RUN) && !hold_reg && stalled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_exc_cnt   <= 32'd0;
      perf_tgt_cnt   <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (perf_exc_hit)   perf_exc_cnt   <= perf_exc_cnt + 32'd1;
      if (perf_tgt_hit)   perf_tgt_cnt   <= perf_tgt_cnt + 32'd1;
      if (perf_stall_hit) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
